imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter: STALL_CNT_W, 16, width of the memory-stall counter.
REQ-002 SHALL have port: clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_i  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: pc_f_i  in  32  current fetch PC from the fetch PC register.
REQ-005 SHALL have port: redirect_i  in  1  branch or jump taken in decode; current fetch is wrong-path.
REQ-006 SHALL have port: stall_d_i  in  1  hazard-unit decode stall; decode cannot accept.
REQ-007 SHALL have port: imem_req_o  out  1  instruction-memory request valid.
REQ-008 SHALL have port: imem_addr_o  out  32  request word address, registered.
REQ-009 SHALL have port: imem_gnt_i  in  1  memory accepts request this cycle.
REQ-010 SHALL have port: imem_rvalid_i  in  1  read data valid.
REQ-011 SHALL have port: imem_rdata_i  in  32  read data.
REQ-012 SHALL have port: instr_f_o  out  32  instruction presented to the decode register.
REQ-013 SHALL have port: instr_valid_o  out  1  instr_f_o valid this cycle.
REQ-014 SHALL have port: stall_f_o  out  1  hold the fetch PC register.
REQ-015 SHALL have port: flush_d_o  out  1  load a bubble into the decode register.
REQ-016 SHALL have port: stall_cnt_o  out  STALL_CNT_W  saturating count of memory-stall cycles.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, DROP_REQ and DROP.
REQ-018 Transitions SHALL be: IDLE->REQ unconditionally.
REQ-019 Transitions SHALL be: REQ->WAIT on imem_gnt_i.
REQ-020 Transitions SHALL be: WAIT->REQ on imem_rvalid_i with delivery; WAIT->HOLD on imem_rvalid_i without delivery.
REQ-021 Transitions SHALL be: HOLD->REQ on delivery.
REQ-022 Transitions SHALL be: DROP_REQ->DROP on imem_gnt_i; DROP->REQ on imem_rvalid_i.
REQ-023 On REQ entry, imem_addr_o SHALL latch pc_f_i; imem_req_o=1 only in REQ and DROP_REQ.
REQ-024 imem_addr_o SHALL stay stable while imem_req_o=1 until imem_gnt_i; a request is never withdrawn.
REQ-025 At most one request SHALL be outstanding; imem_rvalid_i outside WAIT/DROP is ignored.
REQ-026 instr_valid_o SHALL be 1 in WAIT when imem_rvalid_i=1, with instr_f_o=imem_rdata_i (bypass), and 1 in HOLD, with instr_f_o taken from a 32-bit hold buffer; otherwise instr_valid_o=0 and instr_f_o=0.
REQ-027 The hold buffer SHALL capture imem_rdata_i on the WAIT->HOLD transition.
REQ-028 Delivery SHALL be defined as instr_valid_o & ~stall_d_i & ~redirect_i.
REQ-029 Taken redirect SHALL be defined as redirect_i & ~stall_d_i; redirect_i is ignored when stall_d_i=1.
REQ-030 stall_f_o SHALL equal ~(delivery | taken redirect), so the PC loads pc+4 or the target only then.
REQ-031 flush_d_o SHALL equal ~stall_d_i & ~(delivery); this covers no valid instruction and wrong-path squash.
REQ-032 On taken redirect: REQ without imem_gnt_i -> DROP_REQ.
REQ-033 On taken redirect: REQ with imem_gnt_i -> DROP.
REQ-034 On taken redirect: WAIT without imem_rvalid_i -> DROP.
REQ-035 On taken redirect: WAIT with imem_rvalid_i, or HOLD -> REQ, with the data discarded.
REQ-036 On taken redirect in any other state, the normal transition SHALL apply.
REQ-037 In DROP, returned data SHALL never assert instr_valid_o.
REQ-038 Best-case latency SHALL be: request cycle with gnt, data in the next cycle, 2 cycles per instruction.
REQ-039 stall_cnt_o SHALL increment on every cycle with stall_f_o=1 and stall_d_i=0, and saturate at all-ones.

Reset
REQ-040 While rst_i=0: state=IDLE, imem_req_o=0, imem_addr_o=0, hold buffer=0, instr_valid_o=0, instr_f_o=0, stall_cnt_o=0, and stall_f_o=1.
REQ-041 While rst_i=0, flush_d_o SHALL equal ~stall_d_i.
REQ-042 Reset asserted mid-transaction SHALL abandon the outstanding request; the post-reset first request SHALL use the current pc_f_i.

Verification
REQ-043 Zero-wait memory (gnt in the REQ cycle, rvalid one cycle later), pc 0x0,0x4,0x8 -> instructions delivered every 2nd cycle, addresses 0x0/0x4/0x8, stall_f_o=1 in REQ cycles.
REQ-044 gnt delayed 3 cycles at addr 0x100 -> imem_req_o and imem_addr_o=0x100 held 4 cycles; stall_cnt_o increases by the stall-cycle count.
REQ-045 stall_d_i=1 in the rvalid cycle with rdata 0x8C220004, released 2 cycles later -> HOLD, instr_f_o=0x8C220004 valid throughout, delivered on the release cycle, flush_d_o=0 while stalled.
REQ-046 Taken redirect in WAIT before rvalid -> DROP; the returned word is not delivered, the next request uses the new pc_f_i target 0x40.
REQ-047 Taken redirect in REQ without gnt -> old address held until gnt, data dropped, then request at 0x40.
REQ-048 stall_cnt_o preloaded near max (STALL_CNT_W=4, 15 stall cycles, then 3 more) -> counter holds 0xF.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding request on a req/gnt/rvalid memory port,
// with a single-entry hold buffer for decode stalls and squashing of wrong-path fetches.
module imem_fetch_ctrl #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            pc_f_i,
  input  logic                   redirect_i,
  input  logic                   stall_d_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [31:0]            imem_rdata_i,
  output logic [31:0]            instr_f_o,
  output logic                   instr_valid_o,
  output logic                   stall_f_o,
  output logic                   flush_d_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP_REQ,
    DROP
  } state_t;

  state_t      state_q;
  logic [31:0] hold_q;
  logic        delivery;
  logic        taken_redir;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    instr_valid_o = 1'b0;
    instr_f_o     = '0;
    case (state_q)
      WAIT: begin
        if (imem_rvalid_i) begin
          instr_valid_o = 1'b1;
          instr_f_o     = imem_rdata_i;
        end
      end
      HOLD: begin
        instr_valid_o = 1'b1;
        instr_f_o     = hold_q;
      end
      default: begin
        instr_valid_o = 1'b0;
        instr_f_o     = '0;
      end
    endcase
  end

  assign delivery    = instr_valid_o & ~stall_d_i & ~redirect_i;
  assign taken_redir = redirect_i & ~stall_d_i;

  // The PC must not move while reset is held, even if decode signals a redirect.
  assign stall_f_o = ~rst_i | ~(delivery | taken_redir);
  assign flush_d_o = ~stall_d_i & ~delivery;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
      hold_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= REQ;
          imem_req_o  <= 1'b1;
          imem_addr_o <= pc_f_i;
        end
        REQ: begin
          // A granted or pending request cannot be withdrawn; its data is dropped instead.
          if (taken_redir) begin
            state_q    <= imem_gnt_i ? DROP : DROP_REQ;
            imem_req_o <= ~imem_gnt_i;
          end else if (imem_gnt_i) begin
            state_q    <= WAIT;
            imem_req_o <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (taken_redir || delivery) begin
              state_q     <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= pc_f_i;
            end else begin
              state_q <= HOLD;
              hold_q  <= imem_rdata_i;
            end
          end else if (taken_redir) begin
            state_q <= DROP;
          end
        end
        HOLD: begin
          if (taken_redir || delivery) begin
            state_q     <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_f_i;
          end
        end
        DROP_REQ: begin
          if (imem_gnt_i) begin
            state_q    <= DROP;
            imem_req_o <= 1'b0;
          end
        end
        DROP: begin
          if (imem_rvalid_i) begin
            state_q     <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_f_i;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Counts cycles the front end is waiting on memory, not cycles decode is holding it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_f_o && !stall_d_i && (stall_cnt_o != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: inputs change 1 ns after each rising edge, outputs are
// sampled 1 ns later; pc_f_i is driven with the address the next request is expected to latch.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        redirect;
  logic        stall_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic        instr_valid;
  logic        stall_f;
  logic        flush_d;
  logic [15:0] stall_cnt;

  logic        imem_req_4;
  logic [31:0] imem_addr_4;
  logic [31:0] instr_f_4;
  logic        instr_valid_4;
  logic        stall_f_4;
  logic        flush_d_4;
  logic [3:0]  stall_cnt_4;

  int vectors = 0;
  int errors  = 0;

  imem_fetch_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .pc_f_i        (pc_f),
    .redirect_i    (redirect),
    .stall_d_i     (stall_d),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_f_o     (instr_f),
    .instr_valid_o (instr_valid),
    .stall_f_o     (stall_f),
    .flush_d_o     (flush_d),
    .stall_cnt_o   (stall_cnt)
  );

  imem_fetch_ctrl #(.STALL_CNT_W(4)) dut4 (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .pc_f_i        (pc_f),
    .redirect_i    (redirect),
    .stall_d_i     (stall_d),
    .imem_req_o    (imem_req_4),
    .imem_addr_o   (imem_addr_4),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_f_o     (instr_f_4),
    .instr_valid_o (instr_valid_4),
    .stall_f_o     (stall_f_4),
    .flush_d_o     (flush_d_4),
    .stall_cnt_o   (stall_cnt_4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] instr,
                           input logic stf, input logic fld);
    check({tag, ".req"},     32'(imem_req),    32'(req));
    check({tag, ".addr"},    imem_addr,        addr);
    check({tag, ".valid"},   32'(instr_valid), 32'(valid));
    check({tag, ".instr"},   instr_f,          instr);
    check({tag, ".stall_f"}, 32'(stall_f),     32'(stf));
    check({tag, ".flush_d"}, 32'(flush_d),     32'(fld));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    pc_f        = 32'h0;
    redirect    = 1'b0;
    stall_d     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    // Reset values; a redirect during reset must not release the PC.
    #2;
    redirect = 1'b1;
    settle();
    chk_fetch("rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("rst.cnt", 32'(stall_cnt), 32'd0);
    stall_d = 1'b1;
    settle();
    check("rst.flush_stalled", 32'(flush_d), 32'd0);
    redirect = 1'b0;
    stall_d  = 1'b0;
    #7;
    rst_n = 1'b1;

    // Zero-wait memory: 0x0, 0x4, 0x8 delivered every second cycle.
    tick();
    imem_gnt = 1'b1;
    settle();
    chk_fetch("zw.req0", 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000; pc_f = 32'h4;
    settle();
    chk_fetch("zw.data0", 1'b0, 32'h0, 1'b1, 32'hA000_0000, 1'b0, 1'b0);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    settle();
    chk_fetch("zw.req1", 1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0004; pc_f = 32'h8;
    settle();
    chk_fetch("zw.data1", 1'b0, 32'h4, 1'b1, 32'hA000_0004, 1'b0, 1'b0);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    settle();
    chk_fetch("zw.req2", 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0008; pc_f = 32'h100;
    settle();
    chk_fetch("zw.data2", 1'b0, 32'h8, 1'b1, 32'hA000_0008, 1'b0, 1'b0);
    check("zw.cnt", 32'(stall_cnt), 32'd4);

    // Grant delayed three cycles at 0x100: request held four cycles.
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b0;
    settle();
    chk_fetch("gd.c0", 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    settle();
    chk_fetch("gd.c1", 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    settle();
    chk_fetch("gd.c2", 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_gnt = 1'b1;
    settle();
    chk_fetch("gd.c3", 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1);
    check("gd.cnt_before", 32'(stall_cnt), 32'd7);

    // Decode stall in the rvalid cycle: data parked in HOLD, delivered on release.
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C22_0004; stall_d = 1'b1;
    settle();
    check("gd.cnt_after", 32'(stall_cnt), 32'd8);
    chk_fetch("hs.rvalid", 1'b0, 32'h100, 1'b1, 32'h8C22_0004, 1'b1, 1'b0);
    tick();
    imem_rdata = 32'hDEAD_BEEF;
    settle();
    chk_fetch("hs.hold1", 1'b0, 32'h100, 1'b1, 32'h8C22_0004, 1'b1, 1'b0);
    tick();
    imem_rvalid = 1'b0; stall_d = 1'b0; pc_f = 32'h200;
    settle();
    chk_fetch("hs.release", 1'b0, 32'h100, 1'b1, 32'h8C22_0004, 1'b0, 1'b0);
    check("hs.cnt", 32'(stall_cnt), 32'd8);
    tick();
    imem_gnt = 1'b1;
    settle();
    chk_fetch("hs.next_req", 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect in WAIT before rvalid: returned word dropped, next request at 0x40.
    tick();
    imem_gnt = 1'b0; redirect = 1'b1; pc_f = 32'h40;
    settle();
    chk_fetch("rw.redirect", 1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    settle();
    chk_fetch("rw.drop", 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    settle();
    chk_fetch("rw.target", 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; pc_f = 32'h44;
    settle();
    chk_fetch("rw.deliver", 1'b0, 32'h40, 1'b1, 32'h3333_3333, 1'b0, 1'b0);

    // Redirect in REQ without grant: old address held until grant, then 0x40.
    tick();
    imem_rvalid = 1'b0; redirect = 1'b1; pc_f = 32'h40;
    settle();
    chk_fetch("rr.redirect", 1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    redirect = 1'b0;
    settle();
    chk_fetch("rr.held1", 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_gnt = 1'b1;
    settle();
    chk_fetch("rr.held2", 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    settle();
    chk_fetch("rr.drop", 1'b0, 32'h44, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    settle();
    chk_fetch("rr.target", 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1);
    check("rr.cnt", 32'(stall_cnt), 32'd14);

    // Redirect under decode stall is ignored; a later redirect from HOLD discards the word.
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    redirect = 1'b1; stall_d = 1'b1;
    settle();
    chk_fetch("ri.stalled", 1'b0, 32'h40, 1'b1, 32'h4444_4444, 1'b1, 1'b0);
    tick();
    imem_rvalid = 1'b0; stall_d = 1'b0; pc_f = 32'h80;
    settle();
    chk_fetch("ri.hold_redir", 1'b0, 32'h40, 1'b1, 32'h4444_4444, 1'b0, 1'b1);
    tick();
    redirect = 1'b0; imem_gnt = 1'b1;
    settle();
    chk_fetch("ri.target", 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1);

    // Reset in WAIT abandons the request; first request afterwards uses the current pc.
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0; pc_f = 32'h300; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    settle();
    chk_fetch("mr.in_reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("mr.cnt", 32'(stall_cnt), 32'd0);
    check("mr.cnt4", 32'(stall_cnt_4), 32'd0);
    #4;
    rst_n = 1'b1; imem_rvalid = 1'b0;
    tick();
    settle();
    chk_fetch("mr.first_req", 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1);
    check("mr.cnt_after", 32'(stall_cnt), 32'd1);

    // Narrow counter saturation: 15 stall cycles reach 0xF, three more leave it there.
    for (int i = 0; i < 13; i++) tick();
    settle();
    check("sat.cnt4_14", 32'(stall_cnt_4), 32'hE);
    tick();
    settle();
    check("sat.cnt4_15", 32'(stall_cnt_4), 32'hF);
    for (int i = 0; i < 3; i++) tick();
    settle();
    check("sat.cnt4_18", 32'(stall_cnt_4), 32'hF);
    check("sat.cnt16_18", 32'(stall_cnt), 32'd18);
    check("sat.req_held", 32'(imem_req_4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
